// File: rtl/sim_uart_rx_fifo.sv
// sim_uart_rx_fifo: oversampling UART receiver with a show-ahead receive FIFO.
//
// Frame format is set at elaboration: p_data_bits (5..8, LSB first), p_parity
// (0 none, 1 even, 2 odd), p_stop_bits (1 or 2). Every bit is sampled three times
// around its centre at oversample tick rate p_os and decided by majority vote.
// Received frames, with framing/parity/break flags, go into a p_fifo_depth FIFO.
//
// Ports:
//   clk_in    clock, all logic on posedge
//   rst       asynchronous active-high reset
//   scaler    tick divider, one oversample tick every scaler+1 clocks
//   rx        asynchronous serial input, idle high
//   rd_valid  FIFO non-empty, head entry presented on rd_*
//   rd_ready  pops the head when rd_valid is also high
//   rd_data   head data, zero-extended above p_data_bits
//   rd_fe     head framing error (a stop bit sampled 0)
//   rd_pe     head parity error
//   rd_brk    head break (data 0, parity bit 0, stop 0)
//   ovr       sticky overrun flag, ovr_clr clears it (a new overrun wins)
//   count     FIFO occupancy
//   busy      frame reception in progress
module sim_uart_rx_fifo #(
  parameter int unsigned p_data_bits  = 8,
  parameter int unsigned p_parity     = 0,
  parameter int unsigned p_stop_bits  = 1,
  parameter int unsigned p_os         = 16,
  parameter int unsigned p_fifo_depth = 16
) (
  input  logic                            clk_in,
  input  logic                            rst,
  input  logic [31:0]                     scaler,
  input  logic                            rx,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic [7:0]                      rd_data,
  output logic                            rd_fe,
  output logic                            rd_pe,
  output logic                            rd_brk,
  output logic                            ovr,
  input  logic                            ovr_clr,
  output logic [$clog2(p_fifo_depth):0]   count,
  output logic                            busy
);

  localparam int unsigned AW = $clog2(p_fifo_depth);
  localparam int unsigned TW = $clog2(p_os);

  localparam logic [TW-1:0] SampA    = TW'(p_os / 2 - 1);
  localparam logic [TW-1:0] SampB    = TW'(p_os / 2);
  localparam logic [TW-1:0] SampC    = TW'(p_os / 2 + 1);
  localparam logic [TW-1:0] LastTick = TW'(p_os - 1);
  localparam logic [2:0]    LastData = 3'(p_data_bits - 1);
  localparam logic [2:0]    LastStop = 3'(p_stop_bits - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } state_e;

  // ---------------------------------------------------------------------------
  // Oversample tick divider. The limit is captured at reload so a scaler change
  // never truncates or stretches the period already running.
  // ---------------------------------------------------------------------------
  logic [31:0] div_q, div_lim_q;
  logic        tick;

  assign tick = (div_q == div_lim_q);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      div_lim_q <= '0;
    end else if (tick) begin
      div_q     <= '0;
      div_lim_q <= scaler;
    end else begin
      div_q <= div_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // rx synchronizer, preset to the idle level
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          s0_q, s0_d, s1_q, s1_d;
  logic          par_q, par_d, pe_q, pe_d, fe_q, fe_d;

  logic          maj, decide, bit_end, fe_now, par_exp;
  logic          push, push_brk;

  // Third sample is taken live at the decision tick.
  assign maj     = (s0_q & s1_q) | (s0_q & rx_sync_q) | (s1_q & rx_sync_q);
  assign decide  = (tcnt_q == SampC);
  assign bit_end = (tcnt_q == LastTick);
  assign fe_now  = fe_q | ~maj;
  assign par_exp = (p_parity == 2) ? ~(^data_q) : (^data_q);
  assign push_brk = fe_now & (data_q == 8'd0) & ~par_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      tcnt_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      par_q   <= par_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    par_d   = par_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    push    = 1'b0;

    if (tick) begin
      if (state_q != StIdle && state_q != StWaitHigh) begin
        tcnt_d = bit_end ? '0 : tcnt_q + 1'b1;
        if (tcnt_q == SampA) s0_d = rx_sync_q;
        if (tcnt_q == SampB) s1_d = rx_sync_q;
      end

      case (state_q)
        StIdle: begin
          if (!rx_sync_q) begin
            state_d = StStart;
            tcnt_d  = '0;
            data_d  = '0;
            par_d   = 1'b0;
            pe_d    = 1'b0;
            fe_d    = 1'b0;
          end
        end
        StStart: begin
          if (decide && maj) begin
            state_d = StIdle;  // false start
          end else if (bit_end) begin
            state_d = StData;
            bit_d   = '0;
          end
        end
        StData: begin
          if (decide) data_d[bit_q] = maj;
          if (bit_end) begin
            if (bit_q == LastData) begin
              state_d = (p_parity != 0) ? StParity : StStop;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
        StParity: begin
          if (decide) begin
            par_d = maj;
            pe_d  = (maj != par_exp);
          end
          if (bit_end) state_d = StStop;
        end
        StStop: begin
          if (decide) begin
            fe_d = fe_now;
            // Leaving mid-bit lets the next start edge be caught on time.
            if (bit_q == LastStop) begin
              push    = 1'b1;
              state_d = fe_now ? StWaitHigh : StIdle;
            end
          end
          if (bit_end) bit_d = bit_q + 3'd1;
        end
        StWaitHigh: begin
          if (rx_sync_q) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);

  // ---------------------------------------------------------------------------
  // Show-ahead FIFO, pointers carry an extra wrap bit
  // ---------------------------------------------------------------------------
  logic [10:0] mem_q [p_fifo_depth];
  logic [AW:0] wptr_q, rptr_q;
  logic        empty, full, pop, wr_en, ovr_q;
  logic [10:0] head;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = ~empty & rd_ready;
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk_in) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= {push_brk, pe_q, fe_now, data_q};
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (pop)   rptr_q <= rptr_q + 1'b1;
      if (push && full && !pop) ovr_q <= 1'b1;
      else if (ovr_clr)         ovr_q <= 1'b0;
    end
  end

  // Storage is not reset, so the head is gated to keep rd_* at 0 when empty.
  assign head     = mem_q[rptr_q[AW-1:0]];
  assign rd_valid = ~empty;
  assign rd_data  = rd_valid ? head[7:0] : 8'd0;
  assign rd_fe    = rd_valid & head[8];
  assign rd_pe    = rd_valid & head[9];
  assign rd_brk   = rd_valid & head[10];
  assign ovr      = ovr_q;
  assign count    = wptr_q - rptr_q;

endmodule

// File: tb/tb_sim_uart_rx_fifo.sv
// Bench for sim_uart_rx_fifo: two instances (8N1/16x/depth 16 and 8E2/8x/depth 4)
// driven by a bit-level serial sender and checked against a queue-based model.
module tb_sim_uart_rx_fifo;

  localparam int Os0 = 16;
  localparam int Os1 = 8;
  localparam int Depth0 = 16;
  localparam int Depth1 = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] scaler = 32'd0;
  logic        rx0 = 1'b1, rx1 = 1'b1;
  logic        rd_ready0 = 1'b0, rd_ready1 = 1'b0;
  logic        ovr_clr0 = 1'b0, ovr_clr1 = 1'b0;

  logic       rd_valid0, rd_fe0, rd_pe0, rd_brk0, ovr0, busy0;
  logic [7:0] rd_data0;
  logic [4:0] count0;
  logic       rd_valid1, rd_fe1, rd_pe1, rd_brk1, ovr1, busy1;
  logic [7:0] rd_data1;
  logic [2:0] count1;

  sim_uart_rx_fifo #(
    .p_data_bits(8), .p_parity(0), .p_stop_bits(1), .p_os(Os0), .p_fifo_depth(Depth0)
  ) dut0 (
    .clk_in(clk), .rst(rst), .scaler(scaler), .rx(rx0),
    .rd_valid(rd_valid0), .rd_ready(rd_ready0), .rd_data(rd_data0),
    .rd_fe(rd_fe0), .rd_pe(rd_pe0), .rd_brk(rd_brk0),
    .ovr(ovr0), .ovr_clr(ovr_clr0), .count(count0), .busy(busy0)
  );

  sim_uart_rx_fifo #(
    .p_data_bits(8), .p_parity(1), .p_stop_bits(2), .p_os(Os1), .p_fifo_depth(Depth1)
  ) dut1 (
    .clk_in(clk), .rst(rst), .scaler(scaler), .rx(rx1),
    .rd_valid(rd_valid1), .rd_ready(rd_ready1), .rd_data(rd_data1),
    .rd_fe(rd_fe1), .rd_pe(rd_pe1), .rd_brk(rd_brk1),
    .ovr(ovr1), .ovr_clr(ovr_clr1), .count(count1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // rd_valid rise detection, used for push latency measurement
  int   stop_cyc0 = 0, stop_cyc1 = 0;
  int   rise0 = -1000, rise1 = -1000;
  logic rv_last0 = 1'b0, rv_last1 = 1'b0;
  event stop_ev1;

  always @(negedge clk) begin
    if (rd_valid0 && !rv_last0) rise0 = cyc;
    if (rd_valid1 && !rv_last1) rise1 = cyc;
    rv_last0 = rd_valid0;
    rv_last1 = rd_valid1;
  end

  // ---------------------------------------------------------------------------
  // Reference model: expected FIFO contents as {brk, pe, fe, data}
  // ---------------------------------------------------------------------------
  logic [10:0] q0[$];
  logic [10:0] q1[$];
  logic        ovr_exp0 = 1'b0, ovr_exp1 = 1'b0;

  // Parity bit as transmitted: the correct one for the mode, inverted if flip.
  function automatic logic par_bit(input logic [7:0] d, input int mode, input logic flip);
    int ones = $countones(d);
    logic even_bit = (ones % 2 == 1);
    if (mode == 0) return 1'b0;
    return ((mode == 2) ? !even_bit : even_bit) ^ flip;
  endfunction

  function automatic logic [10:0] make_entry(input logic [7:0] d, input int mode,
                                             input logic flip, input logic bad_stop);
    logic pe  = (mode != 0) && flip;
    logic brk = (d == 8'd0) && !par_bit(d, mode, flip) && bad_stop;
    return {brk, pe, bad_stop, d};
  endfunction

  task automatic model_push(input int d, input logic [10:0] e);
    if (d == 0) begin
      if (q0.size() < Depth0) q0.push_back(e);
      else ovr_exp0 = 1'b1;
    end else begin
      if (q1.size() < Depth1) q1.push_back(e);
      else ovr_exp1 = 1'b1;
    end
  endtask

  function automatic logic [31:0] outs(input int d);
    if (d == 0)
      return {13'd0, rd_valid0, rd_data0, rd_fe0, rd_pe0, rd_brk0, ovr0, count0, busy0};
    return {15'd0, rd_valid1, rd_data1, rd_fe1, rd_pe1, rd_brk1, ovr1, count1, busy1};
  endfunction

  function automatic logic [10:0] head(input int d);
    if (d == 0) return {rd_brk0, rd_pe0, rd_fe0, rd_data0};
    return {rd_brk1, rd_pe1, rd_fe1, rd_data1};
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers; inputs always change 1 time unit after a posedge
  // ---------------------------------------------------------------------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int d, input logic v);
    if (d == 0) rx0 = v;
    else rx1 = v;
  endtask

  task automatic send(input int d, input logic [7:0] data, input logic flip,
                      input logic [1:0] stop_low, input int gap_bits);
    int   os    = (d == 0) ? Os0 : Os1;
    int   mode  = (d == 0) ? 0 : 1;
    int   nstop = (d == 0) ? 1 : 2;
    int   bc    = os * (int'(scaler) + 1);
    logic bad   = (d == 0) ? stop_low[0] : |stop_low;
    model_push(d, make_entry(data, mode, flip, bad));
    @(posedge clk);
    #1;
    set_rx(d, 1'b0);
    wait_clks(bc);
    for (int i = 0; i < 8; i++) begin
      set_rx(d, data[i]);
      wait_clks(bc);
    end
    if (mode != 0) begin
      set_rx(d, par_bit(data, mode, flip));
      wait_clks(bc);
    end
    for (int s = 0; s < nstop; s++) begin
      if (s == 0) begin
        if (d == 0) stop_cyc0 = cyc;
        else begin
          stop_cyc1 = cyc;
          -> stop_ev1;
        end
      end
      set_rx(d, !stop_low[s]);
      wait_clks(bc);
    end
    set_rx(d, 1'b1);
    wait_clks(gap_bits * bc);
  endtask

  // Pops every expected entry, holding each head a few cycles to check stability.
  task automatic drain(input int d);
    logic [10:0] e;
    int          n;
    n = (d == 0) ? q0.size() : q1.size();
    for (int k = 0; k < n; k++) begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      @(negedge clk);
      check_eq($sformatf("valid%0d", d), {31'd0, outs(d)[16 + 2 * (1 - d)]}, 32'd1);
      check_eq($sformatf("head%0d", d), {21'd0, head(d)}, {21'd0, e});
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check_eq($sformatf("hold%0d", d), {21'd0, head(d)}, {21'd0, e});
      if (d == 0) rd_ready0 = 1'b1;
      else rd_ready1 = 1'b1;
      @(negedge clk);
      rd_ready0 = 1'b0;
      rd_ready1 = 1'b0;
    end
    @(negedge clk);
    check_eq($sformatf("empty%0d", d), {31'd0, (d == 0) ? rd_valid0 : rd_valid1}, 32'd0);
    check_eq($sformatf("cnt0_%0d", d), (d == 0) ? {27'd0, count0} : {29'd0, count1}, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  int lat;
  int l1;

  initial begin
    wait_clks(3);
    @(negedge clk);
    check_eq("rst_outs0", outs(0), 32'd0);
    check_eq("rst_outs1", outs(1), 32'd0);
    rst = 1'b0;
    wait_clks(4);

    // 8N1 0x55 with push latency from stop-bit start
    scaler = 0;
    send(0, 8'h55, 1'b0, 2'b00, 2);
    @(negedge clk);
    check_eq("cnt_55", {27'd0, count0}, 32'd1);
    lat = rise0 - stop_cyc0;
    check_eq("lat_55", {31'd0, (lat >= 1 && lat <= 16)}, 32'd1);
    drain(0);

    // even parity: wrong then correct parity bit
    send(1, 8'hA5, 1'b1, 2'b00, 1);
    send(1, 8'hA5, 1'b0, 2'b00, 1);
    drain(1);

    // back-to-back with scaler=3, middle frame second stop bit low
    scaler = 3;
    wait_clks(8);
    send(1, 8'h00, 1'b0, 2'b00, 0);
    send(1, 8'hFF, 1'b0, 2'b10, 1);
    send(1, 8'h3C, 1'b0, 2'b00, 1);
    drain(1);

    // line held low 40 bit times gives a single break entry
    scaler = 0;
    wait_clks(8);
    rx1 = 1'b0;
    wait_clks(40 * Os1);
    rx1 = 1'b1;
    model_push(1, make_entry(8'h00, 1, 1'b0, 1'b1));
    wait_clks(4 * Os1);
    @(negedge clk);
    check_eq("brk_busy", {31'd0, busy1}, 32'd0);
    check_eq("brk_cnt", {29'd0, count1}, 32'd1);
    drain(1);

    // single-clock glitches at scaler=7 are rejected
    scaler = 7;
    wait_clks(16);
    for (int i = 0; i < 8; i++) begin
      rx0 = 1'b0;
      wait_clks(1);
      rx0 = 1'b1;
      wait_clks(Os0 * 8 + 3 + i);
      @(negedge clk);
      check_eq($sformatf("glitch_busy%0d", i), {31'd0, busy0}, 32'd0);
    end
    check_eq("glitch_cnt", {27'd0, count0}, 32'd0);
    send(0, 8'hC3, 1'b0, 2'b00, 1);
    drain(0);

    // overrun on a depth-4 FIFO
    scaler = 0;
    wait_clks(8);
    for (int i = 1; i <= 6; i++) begin
      send(1, 8'(i), 1'b0, 2'b00, 1);
      if (i == 1) l1 = rise1 - stop_cyc1;
    end
    @(negedge clk);
    check_eq("ovf_cnt", {29'd0, count1}, 32'd4);
    check_eq("ovf_ovr", {31'd0, ovr1}, {31'd0, ovr_exp1});
    check_eq("ovf_head", {21'd0, head(1)}, {21'd0, q1[0]});
    wait_clks(1);
    ovr_clr1 = 1'b1;
    wait_clks(1);
    ovr_clr1 = 1'b0;
    ovr_exp1 = 1'b0;
    @(negedge clk);
    check_eq("ovr_clr", {31'd0, ovr1}, 32'd0);

    // push into a full FIFO on the same cycle as a pop
    if (l1 < 1 || l1 > 64) begin
      check_eq("lat_cal", l1, 32'd0);
      l1 = 1;
    end
    void'(q1.pop_front());
    fork
      send(1, 8'h07, 1'b0, 2'b00, 1);
      begin
        @(stop_ev1);
        wait_clks(l1 - 1);
        rd_ready1 = 1'b1;
        wait_clks(1);
        rd_ready1 = 1'b0;
      end
    join
    @(negedge clk);
    check_eq("pp_ovr", {31'd0, ovr1}, 32'd0);
    check_eq("pp_cnt", {29'd0, count1}, 32'd4);
    send(1, 8'h08, 1'b0, 2'b00, 1);
    @(negedge clk);
    check_eq("ovf2_ovr", {31'd0, ovr1}, {31'd0, ovr_exp1});
    drain(1);
    check_eq("ovr_sticky", {31'd0, ovr1}, 32'd1);

    // reset in the middle of the data bits
    send(1, 8'h5A, 1'b0, 2'b00, 1);
    rx0 = 1'b0;
    rx1 = 1'b0;
    wait_clks(3 * Os1);
    rst = 1'b1;
    wait_clks(2);
    @(negedge clk);
    check_eq("mid_rst0", outs(0), 32'd0);
    check_eq("mid_rst1", outs(1), 32'd0);
    rx0 = 1'b1;
    rx1 = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    q0.delete();
    q1.delete();
    ovr_exp0 = 1'b0;
    ovr_exp1 = 1'b0;
    wait_clks(20);
    @(negedge clk);
    check_eq("post_rst0", outs(0), 32'd0);
    check_eq("post_rst1", outs(1), 32'd0);
    send(1, 8'h9A, 1'b0, 2'b00, 1);
    send(0, 8'h9A, 1'b0, 2'b00, 1);
    drain(1);
    drain(0);

    // randomized frames
    for (int n = 0; n < 16; n++) begin
      int          d    = int'($urandom_range(0, 1));
      logic [7:0]  data = 8'($urandom);
      logic        flip = (d == 1) ? 1'($urandom) : 1'b0;
      logic        bad  = ($urandom_range(0, 3) == 0);
      logic [1:0]  sl   = bad ? ((d == 1) ? 2'b11 : 2'b01) : 2'b00;
      int          gap  = int'($urandom_range(0, 2));
      if (bad && gap == 0) gap = 1;  // line must return high before the next start
      if ($urandom_range(0, 3) == 0) data = 8'h00;
      scaler = 32'($urandom_range(0, 3));
      wait_clks(4);
      send(d, data, flip, sl, gap);
      if (q0.size() >= 3) drain(0);
      if (q1.size() >= 3) drain(1);
    end
    wait_clks(2 * Os0 * 4);
    drain(0);
    drain(1);
    check_eq("end_ovr0", {31'd0, ovr0}, {31'd0, ovr_exp0});
    check_eq("end_ovr1", {31'd0, ovr1}, {31'd0, ovr_exp1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sim_uart_rx_fifo.md
Name: sim_uart_rx_fifo

Overview:
Parametrised UART receiver for simulation benches and synthesizable VIP use. It is the successor to the single-byte simulation receiver. It adds configurable frame format (data bits, parity, stop bits), configurable oversampling with 3-sample majority voting, framing/parity/break detection, and a show-ahead receive FIFO with overrun reporting. It sits between a DUT UART TX pin and a bench log/checker process that drains the FIFO through a valid/ready port.

Parameters:
p_data_bits, 8, data bits per frame, legal 5..8; LSB first.
p_parity, 0, 0=none, 1=even, 2=odd.
p_stop_bits, 1, stop bits per frame, legal 1 or 2.
p_os, 16, oversample ticks per bit, even, legal 8..32.
p_fifo_depth, 16, FIFO entries, power of 2, >=2.

Ports:
clk_in  in  1  clock; all logic on posedge.
rst  in  1  asynchronous active-high reset.
scaler  in  32  tick divider; one oversample tick every scaler+1 clocks.
rx  in  1  serial input, idle high, asynchronous.
rd_valid  out  1  FIFO non-empty; head entry presented.
rd_ready  in  1  pop head when rd_valid && rd_ready.
rd_data  out  8  head data, zero-extended above p_data_bits.
rd_fe  out  1  head framing error (any stop bit sampled 0).
rd_pe  out  1  head parity error (always 0 when p_parity=0).
rd_brk  out  1  head break (data all 0, parity bit 0 if present, stop 0).
ovr  out  1  sticky overrun flag.
ovr_clr  in  1  clears ovr; set wins on same cycle.
count  out  $clog2(p_fifo_depth)+1  FIFO occupancy.
busy  out  1  frame in progress (state != IDLE).

Behaviour:
- Reset: all outputs 0. FIFO pointers 0, state IDLE, divider 0, 2-flop rx synchronizer preset to 1.
- Tick divider: counts 0..scaler, emits tick on terminal count and reloads 0. scaler=0 gives a tick every clock. A scaler change takes effect at the next reload.
- All rx sampling uses the synchronized rx, on tick cycles only. tcnt counts ticks within a bit.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: on a tick with rx==0, go to START with tcnt=0.
- Bit sampling (all bit states): sample at tcnt = p_os/2-1, p_os/2, p_os/2+1; bit value = majority of the three. The bit ends when tcnt reaches p_os-1.
- START: if the majority is 1, this is a false start; return to IDLE at the decision tick.
- DATA: shift in p_data_bits bits LSB first.
- PARITY (only when p_parity!=0): pe = received bit != expected. Even: XOR of data equals parity bit. Odd: inverse.
- STOP: for each stop bit, the frame is pushed at the majority-decision tick of the last stop bit, not at bit end, so back-to-back frames resync.
- After STOP: if fe is set, go to WAIT_HIGH; otherwise go to IDLE.
- WAIT_HIGH: stay until a tick with rx==1, then go to IDLE. A held-low line therefore produces exactly one break entry.
- FIFO write: when full and no pop in the same cycle, drop the new entry and set ovr. When full with a simultaneous pop, accept the push and do not set ovr.
- FIFO read: show-ahead. rd_* reflect the head combinationally from storage. A push into an empty FIFO makes rd_valid=1 on the next cycle. rd_* are stable while rd_valid && !rd_ready.
- count updates one cycle after push/pop. Simultaneous push+pop leaves count unchanged. Pointers wrap modulo p_fifo_depth, with an extra MSB for full/empty.
- Reset asserted mid-frame: the partial frame is discarded, FIFO is emptied, ovr cleared.
- rx glitch shorter than 2 ticks in IDLE: rejected as a false start, no entry.

Test Plan:
- p_os=16, scaler=0, 8N1, send 0x55 -> one entry rd_data=0x55, fe=pe=brk=0. rd_valid rises within 16 clocks of the stop-bit start edge. count=1.
- p_parity=1 (even), send 0xA5 with parity bit 1 -> pe=1. Send with parity bit 0 -> pe=0, data 0xA5 both times.
- scaler=3, 8N2, back-to-back 0x00,0xFF,0x3C with second stop bit driven 0 on the middle frame -> entries 0x00 fe=0; 0xFF fe=1; 0x3C fe=0, no resync loss.
- Hold rx low for 40 bit times, then release -> exactly one entry, data 0x00, fe=1, brk=1. busy=0 after rx returns high.
- p_fifo_depth=4, rd_ready=0, send 6 frames 0x01..0x06 -> count=4, FIFO holds 0x01..0x04, ovr=1. Pulse ovr_clr -> ovr=0. Push on the same cycle as a pop while full -> ovr stays 0.
- 1-clock low glitch on rx in IDLE (scaler=7) -> no entry, busy returns 0. Assert rst mid-DATA -> all outputs 0 and the next clean frame is received correctly.
